// File: rtl/c_state_ctrl_pkg.sv
// Shared definitions for the c_state_ctrl solver phase controller.
// Holds the controller state encoding and the default geometry
// (ring size, clause SRAM depth, variable-assign length, round width).
package c_state_ctrl_pkg;

  localparam int N_VPE_DEF      = 12;
  localparam int SRAM_DEPTH_DEF = 256;
  localparam int VAR_CYCLES_DEF = 4;
  localparam int ROUND_W_DEF    = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_VAR,
    ST_PROC,
    ST_FIN
  } state_e;

endpackage

// File: rtl/c_state_ctrl_if.sv
// Host <-> controller signal bundle.
//   master: host / clock-driver side (drives start, round budget, SRAM
//           write beats, ring end marker and satisfaction result)
//   slave : controller side (drives write ready, phase controls, status)
interface c_state_ctrl_if #(
  parameter int ROUND_W = 16
) ();
  logic               start;
  logic [ROUND_W-1:0] max_rounds;
  logic               shuffle_en;
  logic               sram_wr_valid;
  logic               sram_wr_ready;
  logic               satisfy_en;
  logic               all_sat;
  logic               sram_state;
  logic               var_state;
  logic               proc_state;
  logic               shuffle;
  logic               done;
  logic               solved;
  logic               error;
  logic [ROUND_W-1:0] round_cnt;

  modport master (
    output start, max_rounds, shuffle_en, sram_wr_valid, satisfy_en, all_sat,
    input  sram_wr_ready, sram_state, var_state, proc_state, shuffle,
           done, solved, error, round_cnt
  );

  modport slave (
    input  start, max_rounds, shuffle_en, sram_wr_valid, satisfy_en, all_sat,
    output sram_wr_ready, sram_state, var_state, proc_state, shuffle,
           done, solved, error, round_cnt
  );
endinterface

// File: rtl/c_state_wdog.sv
// PROC-phase watchdog: counts consecutive cycles with en_i high and flags
// timeout_o during the LIMIT-th such cycle. Dropping en_i clears the count.
//   clk_i, reset_i : clock, synchronous active-high reset
//   en_i           : controller is in PROC
//   timeout_o      : this is the LIMIT-th PROC cycle
module c_state_wdog #(
  parameter int LIMIT = 24
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic en_i,
  output logic timeout_o
);
  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Hold at LAST so a stalled controller cannot wrap the count.
  always_comb begin
    cnt_d = '0;
    if (en_i) cnt_d = (cnt_q == LAST) ? cnt_q : cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign timeout_o = en_i && (cnt_q == LAST);
endmodule

// File: rtl/c_state_ctrl.sv
// Solver phase controller: IDLE -> LOAD (clause words) -> {VAR -> PROC}*
// -> FIN -> IDLE. All outputs are registered from the next state.
//   clk_i, reset_i : clock, synchronous active-high reset
//   bus (slave)    : start/budget, SRAM write handshake, ring marker and
//                    result in; phase controls, shuffle, done/solved/error,
//                    completed-round count out
module c_state_ctrl
  import c_state_ctrl_pkg::*;
#(
  parameter int N_VPE      = N_VPE_DEF,
  parameter int SRAM_DEPTH = SRAM_DEPTH_DEF,
  parameter int VAR_CYCLES = VAR_CYCLES_DEF,
  parameter int ROUND_W    = ROUND_W_DEF
) (
  input  logic          clk_i,
  input  logic          reset_i,
  c_state_ctrl_if.slave bus
);
  localparam int BW = $clog2(SRAM_DEPTH + 1);
  localparam int VW = $clog2(VAR_CYCLES + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(SRAM_DEPTH - 1);
  localparam logic [VW-1:0] LAST_VAR  = VW'(VAR_CYCLES - 1);

  state_e             state_q, state_d;
  logic [BW-1:0]      beat_q, beat_d;
  logic [VW-1:0]      var_q, var_d;
  logic [ROUND_W-1:0] round_q, round_d, max_q, max_d;
  logic               ready_q, sram_q, var_st_q, proc_q, done_q;
  logic               ready_d, sram_d, var_st_d, proc_d, done_d;
  logic               shuf_q, solved_q, error_q;
  logic               shuf_d, solved_d, error_d;
  logic               start_ok, beat, sat, timeout, at_lim;
  logic [ROUND_W:0]   rc_inc, rc_lim;

  assign start_ok = (state_q == ST_IDLE) && bus.start;
  assign beat     = (state_q == ST_LOAD) && bus.sram_wr_valid && ready_q;
  assign sat      = (state_q == ST_PROC) && bus.satisfy_en;

  // A zero budget becomes 2^ROUND_W, i.e. never reached before saturation.
  assign rc_inc = {1'b0, round_q} + (ROUND_W+1)'(1);
  assign rc_lim = {(max_q == '0), max_q};
  assign at_lim = (rc_inc == rc_lim);

  c_state_wdog #(.LIMIT(2 * N_VPE)) u_wdog (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .en_i      (state_q == ST_PROC),
    .timeout_o (timeout)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_LOAD;
      ST_LOAD: if (beat && beat_q == LAST_BEAT) state_d = ST_VAR;
      ST_VAR:  if (var_q == LAST_VAR) state_d = ST_PROC;
      ST_PROC: begin
        if (bus.satisfy_en)   state_d = (bus.all_sat || at_lim) ? ST_FIN : ST_VAR;
        else if (timeout)     state_d = ST_FIN;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the next state, plus sticky status
  always_comb begin
    ready_d  = (state_d == ST_LOAD);
    sram_d   = (state_d == ST_LOAD);
    var_st_d = (state_d == ST_VAR);
    proc_d   = (state_d == ST_PROC);
    done_d   = (state_d == ST_FIN);
    solved_d = solved_q;
    error_d  = error_q;
    shuf_d   = shuf_q;
    if (sat && bus.all_sat)                  solved_d = 1'b1;
    if ((state_q == ST_PROC) && !bus.satisfy_en && timeout) error_d = 1'b1;
    if ((state_q == ST_PROC) && (state_d == ST_VAR)) shuf_d = ~shuf_q;
    if (start_ok) begin
      solved_d = 1'b0;
      error_d  = 1'b0;
    end
    if (start_ok || !bus.shuffle_en) shuf_d = 1'b0;
  end

  // Datapath counters
  always_comb begin
    beat_d  = '0;
    if (state_q == ST_LOAD) beat_d = beat ? beat_q + BW'(1) : beat_q;
    var_d   = (state_q == ST_VAR) ? var_q + VW'(1) : '0;
    round_d = round_q;
    max_d   = max_q;
    if (start_ok) begin
      round_d = '0;
      max_d   = bus.max_rounds;
    end else if (sat) begin
      round_d = (&round_q) ? round_q : round_q + ROUND_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      beat_q   <= '0;
      var_q    <= '0;
      round_q  <= '0;
      max_q    <= '0;
      ready_q  <= 1'b0;
      sram_q   <= 1'b0;
      var_st_q <= 1'b0;
      proc_q   <= 1'b0;
      done_q   <= 1'b0;
      shuf_q   <= 1'b0;
      solved_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      beat_q   <= beat_d;
      var_q    <= var_d;
      round_q  <= round_d;
      max_q    <= max_d;
      ready_q  <= ready_d;
      sram_q   <= sram_d;
      var_st_q <= var_st_d;
      proc_q   <= proc_d;
      done_q   <= done_d;
      shuf_q   <= shuf_d;
      solved_q <= solved_d;
      error_q  <= error_d;
    end
  end

  assign bus.sram_wr_ready = ready_q;
  assign bus.sram_state    = sram_q;
  assign bus.var_state     = var_st_q;
  assign bus.proc_state    = proc_q;
  assign bus.shuffle       = shuf_q;
  assign bus.done          = done_q;
  assign bus.solved        = solved_q;
  assign bus.error         = error_q;
  assign bus.round_cnt     = round_q;
endmodule
